// File: rtl/snn_pkg.sv
// snn_pkg: shared widths, types and the unsigned 8-bit clamp used by the neuron datapath
package snn_pkg;
    localparam int CURRENT_W = 8;
    localparam int WEIGHT_W = 8;
    localparam int RAW_W = 16;
    typedef logic [CURRENT_W-1:0] current_t;
    typedef logic signed [WEIGHT_W-1:0] weight_t;
    function automatic current_t clamp_u8(input logic signed [RAW_W-1:0] v);
        return v < 0 ? '0 : v > 255 ? '1 : v[CURRENT_W-1:0];
    endfunction
endpackage

// File: rtl/syn_weight_rf.sv
// syn_weight_rf: per-synapse signed weight file, one write port, all entries read in parallel
module syn_weight_rf
    import snn_pkg::*;
#(
    parameter int N_SYN = 4,
    localparam int AW = $clog2(N_SYN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  weight_t       wr_data,
    output weight_t       w [N_SYN]
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SYN; i++) w[i] <= '0;
        end else begin
            for (int i = 0; i < N_SYN; i++) if (wr_en && wr_addr == AW'(i)) w[i] <= wr_data;
        end
    end
endmodule

// File: rtl/syn_current_gen.sv
// syn_current_gen: accumulates spike-gated weights with periodic leak into a saturated 8-bit current
module syn_current_gen
    import snn_pkg::*;
#(
    parameter int N_SYN = 4,
    parameter int DECAY_PERIOD = 4,
    parameter int DECAY_SHIFT = 3,
    localparam int AW = $clog2(N_SYN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_SYN-1:0] pre_spike,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  weight_t          wr_data,
    output current_t         current,
    output logic             sat,
    output logic             tick
);
    localparam int SW = WEIGHT_W + AW + 2;
    localparam int CW = DECAY_PERIOD > 1 ? $clog2(DECAY_PERIOD) : 1;
    weight_t w [N_SYN];
    logic signed [SW-1:0] wsum, raw;
    current_t shifted, leak;
    logic leak_now;
    logic [CW-1:0] cnt;
    syn_weight_rf #(.N_SYN(N_SYN)) u_rf (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .w(w)
    );
    always_comb begin
        wsum = '0;
        for (int i = 0; i < N_SYN; i++) if (pre_spike[i]) wsum = wsum + SW'(w[i]);
        leak_now = cnt == CW'(DECAY_PERIOD - 1);
        shifted = current >> DECAY_SHIFT;
        // nonzero accumulator always loses at least one per tick
        leak = !leak_now ? '0 : shifted != 0 ? shifted : current_t'(current != 0);
        raw = $signed(SW'(current)) - $signed(SW'(leak)) + wsum;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current <= '0;
            sat <= 1'b0;
            tick <= 1'b0;
            cnt <= '0;
        end else if (enable) begin
            current <= clamp_u8(RAW_W'(raw));
            sat <= raw < 0 || raw > 255;
            tick <= leak_now;
            cnt <= leak_now ? '0 : CW'(cnt + 1'b1);
        end else begin
            sat <= 1'b0;
            tick <= 1'b0;
        end
    end
endmodule

// File: tb/tb_syn_current_gen.sv
// tb_syn_current_gen: directed plus random stimulus checked against an arithmetic reference model
module tb_syn_current_gen;
    logic clk = 0, rst_n = 0, enable = 0, wr_en = 0;
    logic [3:0] pre_spike = 0;
    logic [1:0] wr_addr = 0;
    logic signed [7:0] wr_data = 0;
    logic [7:0] current;
    logic sat, tick;
    int errors = 0, checks = 0;
    int mw [4];
    int acc = 0, cnt = 0;
    bit m_sat = 0, m_tick = 0;

    syn_current_gen dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pre_spike(pre_spike), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .current(current), .sat(sat), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mw[i] = 0;
        acc = 0; cnt = 0; m_sat = 0; m_tick = 0;
    endtask

    task automatic step(input bit en, input logic [3:0] sp, input bit we, input int wa, input int wd);
        int ws, lk, raw;
        enable = en; pre_spike = sp; wr_en = we; wr_addr = 2'(wa); wr_data = 8'(wd);
        @(posedge clk);
        if (en) begin
            ws = 0;
            for (int i = 0; i < 4; i++) if (sp[i]) ws += mw[i];
            lk = 0;
            if (cnt == 3) lk = (acc / 8 > 0) ? acc / 8 : (acc != 0 ? 1 : 0);
            raw = acc - lk + ws;
            m_sat = raw < 0 || raw > 255;
            acc = raw < 0 ? 0 : raw > 255 ? 255 : raw;
            m_tick = cnt == 3;
            cnt = cnt == 3 ? 0 : cnt + 1;
        end else begin
            m_sat = 0; m_tick = 0;
        end
        if (we) mw[wa] = wd;
        #1;
        check("current", int'(current), acc);
        check("sat", int'(sat), int'(m_sat));
        check("tick", int'(tick), int'(m_tick));
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        model_clear();
        check("rst_current", int'(current), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_tick", int'(tick), 0);
        #4 rst_n = 1;
    endtask

    initial begin
        model_clear();
        @(posedge clk); #1;
        do_reset();
        // basic integrate and first leak tick
        step(0, 0, 1, 0, 40);
        step(1, 4'b0001, 0, 0, 0);
        check("tp1_e1", int'(current), 40);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("tp1_e4", int'(current), 35);
        check("tp1_tick", int'(tick), 1);
        // negative saturation
        step(0, 0, 1, 1, -128);
        step(1, 4'b0010, 0, 0, 0);
        check("neg_sat", int'(sat), 1);
        step(1, 0, 0, 0, 0);
        // positive saturation
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 1, i, 127);
        step(1, 4'hf, 0, 0, 0);
        check("pos_sat_cur", int'(current), 255);
        step(1, 0, 0, 0, 0);
        // minimum leak of one per tick down to zero
        do_reset();
        step(0, 0, 1, 0, 5);
        step(1, 4'b0001, 0, 0, 0);
        for (int i = 0; i < 28; i++) step(1, 0, 0, 0, 0);
        check("minleak_zero", int'(current), 0);
        // same-edge write uses old weight
        do_reset();
        step(0, 0, 1, 2, 50);
        step(1, 4'b0100, 1, 2, 10);
        check("same_edge", int'(current), 50);
        step(1, 4'b0100, 0, 0, 0);
        check("new_weight", int'(current), 60);
        // freeze with spikes present
        for (int i = 0; i < 10; i++) step(0, 4'hf, 0, 0, 0);
        check("frozen", int'(current), 60);
        step(1, 0, 0, 0, 0);
        // async reset mid-run clears weights too
        do_reset();
        step(1, 4'hf, 0, 0, 0);
        check("post_rst", int'(current), 0);
        // random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
